// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX byte channel among N level-handshake sources.
// Each source is offered in turn; one captured byte is buffered and replayed to the transmitter.
module uart_tx_arbiter #(
  parameter int  N_PORTS      = 2,
  parameter int  OFFER_CYCLES = 2,
  localparam int SW           = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_PORTS-1:0]   in_en,
  input  logic [8*N_PORTS-1:0] in_data,
  input  logic [N_PORTS-1:0]   in_valid,
  output logic [N_PORTS-1:0]   in_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic [SW-1:0]        tx_src
);

  localparam int CW = $clog2(OFFER_CYCLES);

  typedef enum logic [2:0] {
    ST_SCAN,
    ST_OFFER,
    ST_GUARD,
    ST_SEND,
    ST_ACK
  } state_t;

  state_t        state_reg, state_next;
  logic [SW-1:0] ptr_reg, ptr_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [7:0]    buf_reg, buf_next;
  logic          tx_valid_reg, tx_valid_next;
  logic [7:0]    tx_data_reg, tx_data_next;
  logic [SW-1:0] tx_src_reg, tx_src_next;

  logic [7:0]    port_data [N_PORTS];
  logic          sel_en;
  logic          sel_valid;
  logic [7:0]    sel_data;
  logic [SW-1:0] ptr_inc;
  logic [SW-1:0] src_inc;

  // in_ready decodes only from registered state and pointer, so it never glitches on inputs.
  generate
    for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_port
      assign port_data[gi] = in_data[8*gi +: 8];
      assign in_ready[gi]  = (state_reg == ST_OFFER) && (ptr_reg == SW'(gi));
    end
  endgenerate

  assign sel_en    = in_en[ptr_reg];
  assign sel_valid = in_valid[ptr_reg];
  assign sel_data  = port_data[ptr_reg];

  assign ptr_inc = (ptr_reg == SW'(N_PORTS - 1)) ? '0 : ptr_reg + SW'(1);
  assign src_inc = (tx_src_reg == SW'(N_PORTS - 1)) ? '0 : tx_src_reg + SW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_SCAN;
      ptr_reg      <= '0;
      cnt_reg      <= '0;
      buf_reg      <= '0;
      tx_valid_reg <= 1'b0;
      tx_data_reg  <= '0;
      tx_src_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      cnt_reg      <= cnt_next;
      buf_reg      <= buf_next;
      tx_valid_reg <= tx_valid_next;
      tx_data_reg  <= tx_data_next;
      tx_src_reg   <= tx_src_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    cnt_next      = cnt_reg;
    buf_next      = buf_reg;
    tx_valid_next = tx_valid_reg;
    tx_data_next  = tx_data_reg;
    tx_src_next   = tx_src_reg;

    case (state_reg)
      ST_SCAN: begin
        // A port still holding valid high has not seen its consumption yet; skip it.
        if (sel_en && !sel_valid) begin
          state_next = ST_OFFER;
          cnt_next   = '0;
        end else begin
          ptr_next = ptr_inc;
        end
      end

      ST_OFFER: begin
        if (sel_valid) begin
          buf_next    = sel_data;
          tx_src_next = ptr_reg;
          state_next  = ST_SEND;
        end else if (cnt_reg == CW'(OFFER_CYCLES - 1)) begin
          state_next = ST_GUARD;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end

      ST_GUARD: begin
        // Catches a source that saw ready on the final offer edge and answered one cycle late.
        if (sel_valid) begin
          buf_next    = sel_data;
          tx_src_next = ptr_reg;
          state_next  = ST_SEND;
        end else begin
          ptr_next   = ptr_inc;
          state_next = ST_SCAN;
        end
      end

      ST_SEND: begin
        if (tx_ready) begin
          tx_valid_next = 1'b1;
          tx_data_next  = buf_reg;
          state_next    = ST_ACK;
        end
      end

      ST_ACK: begin
        if (!tx_ready) begin
          tx_valid_next = 1'b0;
          tx_data_next  = '0;
          ptr_next      = src_inc;
          state_next    = ST_SCAN;
        end
      end

      default: begin
        state_next = ST_SCAN;
      end
    endcase
  end

  assign tx_valid = tx_valid_reg;
  assign tx_data  = tx_data_reg;
  assign tx_src   = tx_src_reg;

endmodule
